// File: rtl/ccu_snoop_responder.sv
// ACE snoop responder: takes one AC snoop, looks up the tag, answers on CR,
// streams the line on CD when data is transferred, then commits the state change.
module ccu_snoop_responder #(
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned LineBytes = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ac_valid_i,
    output logic                 ac_ready_o,
    input  logic [AddrWidth-1:0] ac_addr_i,
    input  logic [3:0]           ac_snoop_i,
    input  logic [2:0]           ac_prot_i,
    output logic                 cr_valid_o,
    input  logic                 cr_ready_i,
    output logic [4:0]           cr_resp_o,
    output logic                 cd_valid_o,
    input  logic                 cd_ready_i,
    output logic [DataWidth-1:0] cd_data_o,
    output logic                 cd_last_o,
    output logic                 lkp_valid_o,
    input  logic                 lkp_ready_i,
    output logic [AddrWidth-1:0] lkp_addr_o,
    input  logic                 lkp_rsp_valid_i,
    input  logic                 lkp_hit_i,
    input  logic                 lkp_dirty_i,
    input  logic                 lkp_unique_i,
    input  logic                 rd_valid_i,
    output logic                 rd_ready_o,
    input  logic [DataWidth-1:0] rd_data_i,
    output logic                 upd_valid_o,
    input  logic                 upd_ready_i,
    output logic [AddrWidth-1:0] upd_addr_o,
    output logic                 upd_inval_o,
    output logic                 upd_clean_o,
    output logic                 upd_shared_o
);

    localparam int unsigned DataBeats = (LineBytes * 8) / DataWidth;
    localparam int unsigned BeatW     = (DataBeats > 1) ? $clog2(DataBeats) : 1;
    localparam logic [BeatW-1:0]     LastBeat = BeatW'(DataBeats - 1);
    localparam logic [AddrWidth-1:0] LineMask = ~AddrWidth'(LineBytes - 1);

    localparam logic [3:0] ReadOnce           = 4'd0;
    localparam logic [3:0] ReadShared         = 4'd1;
    localparam logic [3:0] ReadClean          = 4'd2;
    localparam logic [3:0] ReadNotSharedDirty = 4'd3;
    localparam logic [3:0] ReadUnique         = 4'd7;
    localparam logic [3:0] CleanShared        = 4'd8;
    localparam logic [3:0] CleanInvalid       = 4'd9;
    localparam logic [3:0] MakeInvalid        = 4'd13;

    typedef enum logic [2:0] {
        IDLE, LOOKUP, WAIT_TAG, SEND_CR, SEND_CD, UPDATE
    } state_t;

    state_t               state_q, state_d;
    logic [AddrWidth-1:0] addr_q;
    logic [3:0]           snoop_q;
    logic [2:0]           prot_q;
    logic [4:0]           resp_q, resp_d;
    logic                 need_upd_q, need_upd_d;
    logic                 inval_q, inval_d;
    logic                 clean_q, clean_d;
    logic                 shared_q, shared_d;
    logic [BeatW-1:0]     beat_q;
    logic                 cd_hs;
    logic                 unused_prot;

    assign unused_prot = ^prot_q;
    assign cd_hs       = (state_q == SEND_CD) && rd_valid_i && cd_ready_i;

    // Response/update decode; resp = {WasUnique, IsShared, PassDirty, Error, DataTransfer}
    always_comb begin
        resp_d     = '0;
        need_upd_d = 1'b0;
        inval_d    = 1'b0;
        clean_d    = 1'b0;
        shared_d   = 1'b0;
        if (lkp_hit_i) begin
            case (snoop_q)
                ReadOnce: resp_d = {lkp_unique_i, 1'b1, 1'b0, 1'b0, 1'b1};
                ReadShared, ReadNotSharedDirty: begin
                    resp_d     = {lkp_unique_i, 1'b1, lkp_dirty_i, 1'b0, 1'b1};
                    need_upd_d = 1'b1;
                    shared_d   = 1'b1;
                    clean_d    = lkp_dirty_i;
                end
                ReadClean: begin
                    resp_d     = {lkp_unique_i, 1'b1, 1'b0, 1'b0, 1'b1};
                    need_upd_d = 1'b1;
                    shared_d   = 1'b1;
                end
                ReadUnique: begin
                    resp_d     = {lkp_unique_i, 1'b0, lkp_dirty_i, 1'b0, 1'b1};
                    need_upd_d = 1'b1;
                    inval_d    = 1'b1;
                end
                CleanInvalid: begin
                    resp_d     = {lkp_unique_i, 1'b0, lkp_dirty_i, 1'b0, lkp_dirty_i};
                    need_upd_d = 1'b1;
                    inval_d    = 1'b1;
                end
                CleanShared: begin
                    resp_d     = {lkp_unique_i, 1'b1, lkp_dirty_i, 1'b0, lkp_dirty_i};
                    need_upd_d = 1'b1;
                    clean_d    = 1'b1;
                    shared_d   = 1'b1;
                end
                MakeInvalid: begin
                    resp_d     = {lkp_unique_i, 1'b0, 1'b0, 1'b0, 1'b0};
                    need_upd_d = 1'b1;
                    inval_d    = 1'b1;
                end
                default: resp_d = 5'b00010;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            snoop_q    <= '0;
            prot_q     <= '0;
            resp_q     <= '0;
            need_upd_q <= 1'b0;
            inval_q    <= 1'b0;
            clean_q    <= 1'b0;
            shared_q   <= 1'b0;
            beat_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && ac_valid_i) begin
                addr_q  <= ac_addr_i;
                snoop_q <= ac_snoop_i;
                prot_q  <= ac_prot_i;
            end
            if (state_q == WAIT_TAG && lkp_rsp_valid_i) begin
                resp_q     <= resp_d;
                need_upd_q <= need_upd_d;
                inval_q    <= inval_d;
                clean_q    <= clean_d;
                shared_q   <= shared_d;
            end
            if (cd_hs) begin
                beat_q <= (beat_q == LastBeat) ? '0 : beat_q + BeatW'(1);
            end
        end
    end

    // Next state and handshake outputs; CD beats pass straight through from the cache
    always_comb begin
        state_d     = state_q;
        ac_ready_o  = 1'b0;
        lkp_valid_o = 1'b0;
        cr_valid_o  = 1'b0;
        cd_valid_o  = 1'b0;
        cd_last_o   = 1'b0;
        rd_ready_o  = 1'b0;
        upd_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                ac_ready_o = !rst_i;
                if (ac_valid_i) state_d = LOOKUP;
            end
            LOOKUP: begin
                lkp_valid_o = 1'b1;
                if (lkp_ready_i) state_d = WAIT_TAG;
            end
            WAIT_TAG: begin
                if (lkp_rsp_valid_i) state_d = SEND_CR;
            end
            SEND_CR: begin
                cr_valid_o = 1'b1;
                if (cr_ready_i) begin
                    if (resp_q[0])       state_d = SEND_CD;
                    else if (need_upd_q) state_d = UPDATE;
                    else                 state_d = IDLE;
                end
            end
            SEND_CD: begin
                cd_valid_o = rd_valid_i;
                rd_ready_o = cd_ready_i;
                cd_last_o  = (beat_q == LastBeat);
                if (cd_hs && beat_q == LastBeat) state_d = need_upd_q ? UPDATE : IDLE;
            end
            UPDATE: begin
                upd_valid_o = 1'b1;
                if (upd_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cd_data_o    = rd_data_i;
    assign cr_resp_o    = resp_q;
    assign lkp_addr_o   = addr_q & LineMask;
    assign upd_addr_o   = addr_q & LineMask;
    assign upd_inval_o  = inval_q;
    assign upd_clean_o  = clean_q;
    assign upd_shared_o = shared_q;

endmodule

// File: tb/tb_ccu_snoop_responder.sv
// Directed bench for ccu_snoop_responder: walks snoops through lookup, CR, CD and
// update with hand-computed responses, backpressure and a reset in mid-burst.
module tb_ccu_snoop_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        ac_valid, ac_ready;
    logic [63:0] ac_addr;
    logic [3:0]  ac_snoop;
    logic [2:0]  ac_prot;
    logic        cr_valid, cr_ready;
    logic [4:0]  cr_resp;
    logic        cd_valid, cd_ready, cd_last;
    logic [63:0] cd_data;
    logic        lkp_valid, lkp_ready;
    logic [63:0] lkp_addr;
    logic        lkp_rsp_valid, lkp_hit, lkp_dirty, lkp_unique;
    logic        rd_valid, rd_ready;
    logic [63:0] rd_data;
    logic        upd_valid, upd_ready;
    logic [63:0] upd_addr;
    logic        upd_inval, upd_clean, upd_shared;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ccu_snoop_responder dut (
        .clk_i(clk), .rst_i(rst),
        .ac_valid_i(ac_valid), .ac_ready_o(ac_ready), .ac_addr_i(ac_addr),
        .ac_snoop_i(ac_snoop), .ac_prot_i(ac_prot),
        .cr_valid_o(cr_valid), .cr_ready_i(cr_ready), .cr_resp_o(cr_resp),
        .cd_valid_o(cd_valid), .cd_ready_i(cd_ready), .cd_data_o(cd_data), .cd_last_o(cd_last),
        .lkp_valid_o(lkp_valid), .lkp_ready_i(lkp_ready), .lkp_addr_o(lkp_addr),
        .lkp_rsp_valid_i(lkp_rsp_valid), .lkp_hit_i(lkp_hit), .lkp_dirty_i(lkp_dirty),
        .lkp_unique_i(lkp_unique),
        .rd_valid_i(rd_valid), .rd_ready_o(rd_ready), .rd_data_i(rd_data),
        .upd_valid_o(upd_valid), .upd_ready_i(upd_ready), .upd_addr_o(upd_addr),
        .upd_inval_o(upd_inval), .upd_clean_o(upd_clean), .upd_shared_o(upd_shared)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // One full snoop; abort_at >= 0 asserts reset once that many CD beats have completed
    task automatic run_snoop(input string name, input logic [63:0] addr, input logic [3:0] code,
                             input logic hit, input logic dirty, input logic uniq,
                             input logic [4:0] exp_resp, input logic exp_upd,
                             input logic exp_inval, input logic exp_clean, input logic exp_shared,
                             input logic [63:0] base, input int stall, input bit toggle,
                             input int abort_at);
        int b;
        int cyc;
        @(negedge clk);
        chk({name, ".ac_ready_idle"}, 64'(ac_ready), 64'd1);
        ac_valid = 1'b1; ac_addr = addr; ac_snoop = code; ac_prot = 3'd2;
        @(negedge clk);
        ac_valid = 1'b0;
        for (int i = 0; i < stall; i++) begin
            chk({name, ".lkp_hold"}, 64'(lkp_valid), 64'd1);
            @(negedge clk);
        end
        chk({name, ".lkp_valid"}, 64'(lkp_valid), 64'd1);
        chk({name, ".lkp_addr"}, lkp_addr, addr & ~64'h3F);
        chk({name, ".ac_ready_busy"}, 64'(ac_ready), 64'd0);
        lkp_ready = 1'b1;
        @(negedge clk);
        lkp_ready = 1'b0;
        lkp_rsp_valid = 1'b1; lkp_hit = hit; lkp_dirty = dirty; lkp_unique = uniq;
        @(negedge clk);
        lkp_rsp_valid = 1'b0;
        for (int i = 0; i < stall; i++) begin
            chk({name, ".cr_hold_valid"}, 64'(cr_valid), 64'd1);
            chk({name, ".cr_hold_resp"}, 64'(cr_resp), 64'(exp_resp));
            @(negedge clk);
        end
        chk({name, ".cr_valid"}, 64'(cr_valid), 64'd1);
        chk({name, ".cr_resp"}, 64'(cr_resp), 64'(exp_resp));
        cr_ready = 1'b1;
        @(negedge clk);
        cr_ready = 1'b0;
        if (exp_resp[0]) begin
            b = 0;
            cyc = 0;
            rd_valid = 1'b1;
            while (b < 8 && cyc < 64) begin
                if (abort_at >= 0 && b == abort_at) begin
                    cd_ready = 1'b1;
                    rst = 1'b1;
                    #1;
                    chk({name, ".rst_cd_valid"}, 64'(cd_valid), 64'd0);
                    chk({name, ".rst_ac_ready"}, 64'(ac_ready), 64'd0);
                    chk({name, ".rst_rd_ready"}, 64'(rd_ready), 64'd0);
                    @(negedge clk);
                    rst = 1'b0; rd_valid = 1'b0; cd_ready = 1'b0;
                    #1;
                    chk({name, ".post_rst_ac_ready"}, 64'(ac_ready), 64'd1);
                    return;
                end
                rd_data = base + 64'(b);
                cd_ready = toggle ? (cyc % 2 == 0) : 1'b1;
                #1;
                chk({name, ".cd_valid"}, 64'(cd_valid), 64'd1);
                chk({name, ".cd_data"}, cd_data, base + 64'(b));
                chk({name, ".cd_last"}, 64'(cd_last), 64'(b == 7));
                chk({name, ".rd_ready"}, 64'(rd_ready), 64'(cd_ready));
                @(posedge clk);
                if (cd_ready) b++;
                cyc++;
                @(negedge clk);
            end
            chk({name, ".cd_beats"}, 64'(b), 64'd8);
            rd_valid = 1'b0; cd_ready = 1'b0;
        end else begin
            rd_valid = 1'b1; cd_ready = 1'b1;
            #1;
            chk({name, ".no_cd_valid"}, 64'(cd_valid), 64'd0);
            chk({name, ".no_rd_ready"}, 64'(rd_ready), 64'd0);
            rd_valid = 1'b0; cd_ready = 1'b0;
        end
        if (exp_upd) begin
            chk({name, ".upd_valid"}, 64'(upd_valid), 64'd1);
            chk({name, ".upd_addr"}, upd_addr, addr & ~64'h3F);
            chk({name, ".upd_flags"}, 64'({upd_inval, upd_clean, upd_shared}),
                64'({exp_inval, exp_clean, exp_shared}));
            upd_ready = 1'b1;
            @(negedge clk);
            upd_ready = 1'b0;
        end else begin
            chk({name, ".no_upd"}, 64'(upd_valid), 64'd0);
        end
        chk({name, ".ac_ready_back"}, 64'(ac_ready), 64'd1);
        chk({name, ".cr_idle"}, 64'(cr_valid), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        ac_valid = 1'b0; ac_addr = '0; ac_snoop = '0; ac_prot = '0;
        cr_ready = 1'b0; cd_ready = 1'b0;
        lkp_ready = 1'b0; lkp_rsp_valid = 1'b0; lkp_hit = 1'b0; lkp_dirty = 1'b0; lkp_unique = 1'b0;
        rd_valid = 1'b0; rd_data = '0; upd_ready = 1'b0;
        #12;
        chk("rst.ac_ready", 64'(ac_ready), 64'd0);
        chk("rst.valids", 64'({cr_valid, cd_valid, lkp_valid, upd_valid, rd_ready}), 64'd0);
        chk("rst.cr_resp", 64'(cr_resp), 64'd0);
        chk("rst.flags", 64'({cd_last, upd_inval, upd_clean, upd_shared}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst.release_ac_ready", 64'(ac_ready), 64'd1);

        //        name     addr          code   h     d     u     resp    upd  inv  cln  shr  base     stall tog abort
        run_snoop("miss",  64'h1040, 4'd1,  1'b0, 1'b0, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 64'h00, 0, 1'b0, -1);
        run_snoop("rs_du", 64'h1048, 4'd1,  1'b1, 1'b1, 1'b1, 5'h1D, 1'b1, 1'b0, 1'b1, 1'b1, 64'hA0, 0, 1'b0, -1);
        run_snoop("ru_cu", 64'h2000, 4'd7,  1'b1, 1'b0, 1'b1, 5'h11, 1'b1, 1'b1, 1'b0, 1'b0, 64'hB0, 0, 1'b0, -1);
        run_snoop("mi_u",  64'h3000, 4'd13, 1'b1, 1'b1, 1'b1, 5'h10, 1'b1, 1'b1, 1'b0, 1'b0, 64'h00, 0, 1'b0, -1);
        run_snoop("mi_s",  64'h3040, 4'd13, 1'b1, 1'b1, 1'b0, 5'h00, 1'b1, 1'b1, 1'b0, 1'b0, 64'h00, 0, 1'b0, -1);
        run_snoop("bad",   64'h4000, 4'd15, 1'b1, 1'b0, 1'b0, 5'h02, 1'b0, 1'b0, 1'b0, 1'b0, 64'h00, 0, 1'b0, -1);
        run_snoop("ci_d",  64'h5000, 4'd9,  1'b1, 1'b1, 1'b0, 5'h05, 1'b1, 1'b1, 1'b0, 1'b0, 64'hE0, 0, 1'b0, -1);
        run_snoop("cs_c",  64'h5040, 4'd8,  1'b1, 1'b0, 1'b1, 5'h18, 1'b1, 1'b0, 1'b1, 1'b1, 64'h00, 0, 1'b0, -1);
        run_snoop("ro_du", 64'h6000, 4'd0,  1'b1, 1'b1, 1'b1, 5'h19, 1'b0, 1'b0, 1'b0, 1'b0, 64'hF0, 0, 1'b0, -1);
        run_snoop("rc_d",  64'h6040, 4'd2,  1'b1, 1'b1, 1'b0, 5'h09, 1'b1, 1'b0, 1'b0, 1'b1, 64'h50, 0, 1'b0, -1);
        run_snoop("bp",    64'h7008, 4'd3,  1'b1, 1'b1, 1'b0, 5'h0D, 1'b1, 1'b0, 1'b1, 1'b1, 64'h70, 5, 1'b1, -1);
        run_snoop("abort", 64'h8000, 4'd7,  1'b1, 1'b0, 1'b1, 5'h11, 1'b1, 1'b1, 1'b0, 1'b0, 64'hC0, 0, 1'b0, 4);
        run_snoop("after", 64'h8000, 4'd7,  1'b1, 1'b0, 1'b1, 5'h11, 1'b1, 1'b1, 1'b0, 1'b0, 64'hD0, 0, 1'b0, -1);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
